mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory interface, sitting between the MEM pipeline stage and the word-wide data RAM.
- Turns byte, halfword and word load/store requests into RAM transactions on ce/we/addr/data/ack.
- Sub-word stores are done as read-modify-write, because the RAM only writes whole words.
- Loads get extraction and sign/zero extension; misaligned accesses are flagged; the pipeline is stalled until each access completes.

---
 rtl/mem_ctrl_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 86 ++++++++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared definitions for the data-memory access controller:
//               load/store operation codes, controller state encoding and
//               big-endian lane-select constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

   // Operation codes presented by the MEM stage on op[2:0].
   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LH  = 3'd1,
      OP_LW  = 3'd2,
      OP_LBU = 3'd3,
      OP_LHU = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } op_e;

   // Controller states.
   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_RD      = 3'd1;
   localparam logic [2:0] c_ST_RESP    = 3'd2;
   localparam logic [2:0] c_ST_RMW_RD  = 3'd3;
   localparam logic [2:0] c_ST_MERGE   = 3'd4;
   localparam logic [2:0] c_ST_WR_REQ  = 3'd5;
   localparam logic [2:0] c_ST_WR_WAIT = 3'd6;

   // Big-endian lanes: byte address offset 0 is the most significant byte.
   localparam logic [1:0] c_LANE_B0 = 2'd0;   // bits 31:24
   localparam logic [1:0] c_LANE_B1 = 2'd1;   // bits 23:16
   localparam logic [1:0] c_LANE_B2 = 2'd2;   // bits 15:8
   localparam logic [1:0] c_LANE_B3 = 2'd3;   // bits 7:0
   localparam logic       c_LANE_H0 = 1'b0;   // bits 31:16 (selected by addr[1])

   function automatic logic is_store(input op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational lane logic for the memory access controller.
//               - load path : select byte/half/word from the RAM word and
//                             sign- or zero-extend it
//               - store path: replace the addressed byte/half inside the RAM
//                             word (read-modify-write merge)
//               - flags misaligned halfword/word accesses
// Ports       : i_op, i_addr_lo  operation and byte offset within the word
//               i_ram_rdata      word read from RAM
//               i_wdata          store operand (low bits for SB/SH)
//               o_load_data      extended load result
//               o_merge_data     word to write back for stores
//               o_misaligned     access violates natural alignment
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  op_e         i_op,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_ram_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_data,
   output logic        o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_ram_rdata[7:0];
      case (i_addr_lo)
         c_LANE_B0: w_byte = i_ram_rdata[31:24];
         c_LANE_B1: w_byte = i_ram_rdata[23:16];
         c_LANE_B2: w_byte = i_ram_rdata[15:8];
         default:   w_byte = i_ram_rdata[7:0];
      endcase
      w_half = (i_addr_lo[1] == c_LANE_H0) ? i_ram_rdata[31:16] : i_ram_rdata[15:0];
   end

   always_comb begin
      o_load_data = 32'h0;
      case (i_op)
         OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_load_data = {24'h0, w_byte};
         OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
         OP_LHU:  o_load_data = {16'h0, w_half};
         OP_LW:   o_load_data = i_ram_rdata;
         default: o_load_data = 32'h0;
      endcase
   end

   always_comb begin
      o_merge_data = i_ram_rdata;
      case (i_op)
         OP_SB: begin
            case (i_addr_lo)
               c_LANE_B0: o_merge_data[31:24] = i_wdata[7:0];
               c_LANE_B1: o_merge_data[23:16] = i_wdata[7:0];
               c_LANE_B2: o_merge_data[15:8]  = i_wdata[7:0];
               default:   o_merge_data[7:0]   = i_wdata[7:0];
            endcase
         end
         OP_SH: begin
            if (i_addr_lo[1] == c_LANE_H0) o_merge_data[31:16] = i_wdata[15:0];
            else                           o_merge_data[15:0]  = i_wdata[15:0];
         end
         OP_SW:   o_merge_data = i_wdata;
         default: o_merge_data = i_ram_rdata;
      endcase
   end

   always_comb begin
      o_misaligned = 1'b0;
      case (i_op)
         OP_LH, OP_LHU, OP_SH: o_misaligned = i_addr_lo[0];
         OP_LW, OP_SW:         o_misaligned = |i_addr_lo;
         default:              o_misaligned = 1'b0;
      endcase
   end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Initiator side of the data-memory interface. Converts byte,
//               halfword and word loads/stores from the MEM stage into
//               word-wide RAM transactions; sub-word stores are done as
//               read-modify-write. Stalls the pipeline until each access
//               completes and flags misaligned accesses.
// Ports       : clk, rst (sync, active-low)
//               req/op/addr/wdata      request from the MEM stage
//               stall_req/done/rdata/misalign  status back to the pipeline
//               ram_ce/ram_we/ram_addr/ram_wdata/ram_rdata/ram_ack  RAM side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall_req,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic              ram_ack
);

   generate
      if (DATA_W != 32) begin : g_bad_data_w
         $error("mem_access_ctrl: only DATA_W = 32 is supported");
      end
   endgenerate

   logic [2:0]        r_state;
   op_e               r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_wbuf;
   logic [31:0]       r_rdata;
   logic              r_done;
   logic              r_mis;

   logic              w_idle;
   logic              w_accept;
   op_e               w_sel_op;
   logic [1:0]        w_sel_lo;
   logic [31:0]       w_load_data;
   logic [31:0]       w_merge_data;
   logic              w_misaligned;

   // A req seen in the done cycle still belongs to the finishing instruction,
   // and nothing is accepted while reset is asserted.
   assign w_idle   = (r_state == c_ST_IDLE);
   assign w_accept = w_idle && req && !r_done && rst;

   // In IDLE only the misalignment flag of the incoming request matters;
   // in every other state the lane logic works on the latched request.
   assign w_sel_op = w_idle ? op_e'(op)  : r_op;
   assign w_sel_lo = w_idle ? addr[1:0] : r_addr[1:0];

   mem_lane_align u_lane_align (
      .i_op         (w_sel_op),
      .i_addr_lo    (w_sel_lo),
      .i_ram_rdata  (ram_rdata),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_merge_data (w_merge_data),
      .o_misaligned (w_misaligned)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= c_ST_IDLE;
         r_done  <= 1'b0;
         r_mis   <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         r_done <= 1'b0;
         r_mis  <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_op    <= op_e'(op);
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  if (w_misaligned) begin
                     r_done  <= 1'b1;
                     r_mis   <= 1'b1;
                     r_rdata <= 32'h0;
                  end else if (op_e'(op) == OP_SW) begin
                     r_wbuf  <= wdata;
                     r_state <= c_ST_WR_REQ;
                  end else if (is_store(op_e'(op))) begin
                     r_state <= c_ST_RMW_RD;
                  end else begin
                     r_state <= c_ST_RD;
                  end
               end
            end
            c_ST_RD:     r_state <= c_ST_RESP;
            c_ST_RESP: begin
               r_rdata <= w_load_data;
               r_done  <= 1'b1;
               r_state <= c_ST_IDLE;
            end
            c_ST_RMW_RD: r_state <= c_ST_MERGE;
            c_ST_MERGE: begin
               r_wbuf  <= w_merge_data;
               r_state <= c_ST_WR_REQ;
            end
            // First write cycle never completes, whatever ram_ack says.
            c_ST_WR_REQ: r_state <= c_ST_WR_WAIT;
            c_ST_WR_WAIT: begin
               if (ram_ack) begin
                  r_done  <= 1'b1;
                  r_rdata <= 32'h0;
                  r_state <= c_ST_IDLE;
               end
            end
            default:     r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign ram_ce    = (r_state == c_ST_RD)     || (r_state == c_ST_RMW_RD) ||
                      (r_state == c_ST_WR_REQ) || (r_state == c_ST_WR_WAIT);
   assign ram_we    = (r_state == c_ST_WR_REQ) || (r_state == c_ST_WR_WAIT);
   assign ram_addr  = {r_addr[ADDR_W-1:2], 2'b00};
   assign ram_wdata = r_wbuf;

   assign stall_req = !w_idle || w_accept;
   assign done      = r_done;
   assign misalign  = r_mis;
   assign rdata     = r_rdata;

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a word RAM model
//               (registered read, programmable write-ack delay) and a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;
   import mem_ctrl_pkg::*;

   localparam int K_LOAD = 0;
   localparam int K_RMW  = 1;
   localparam int K_SW   = 2;
   localparam int K_MIS  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall_req, done, misalign, ram_ce, ram_we, ram_ack;
   logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .stall_req(stall_req), .done(done), .rdata(rdata), .misalign(misalign),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_val(input int i);
      if (i == 32'h40) return 32'h8899AABB;
      return (i * 32'h01030507) ^ 32'h5A5A0F0F;
   endfunction

   // ---------------- RAM model ----------------
   logic [31:0] ram_mem [0:255];
   logic        mem_init = 1'b1;
   int          wcnt = 0;
   int          extra_lat = 0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
      end else begin
         if (ram_ce && !ram_we) ram_rdata <= ram_mem[ram_addr[9:2]];
         if (ram_ce && ram_we && ram_ack) ram_mem[ram_addr[9:2]] <= ram_wdata;
      end
      if (ram_ce && ram_we) wcnt <= wcnt + 1;
      else                  wcnt <= 0;
   end
   assign ram_ack = ram_ce && ram_we && (wcnt >= 1 + extra_lat);

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:255];

   function automatic bit model_mis(input logic [2:0] o, input logic [31:0] a);
      if (o == OP_LH || o == OP_LHU || o == OP_SH) return (a % 2) != 0;
      if (o == OP_LW || o == OP_SW) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] w);
      int sh;
      logic [31:0] v;
      v = 32'h0;
      if (o == OP_LB || o == OP_LBU) begin
         sh = 8 * (3 - int'(a[1:0]));
         v  = (w >> sh) & 32'hFF;
         if (o == OP_LB && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else if (o == OP_LH || o == OP_LHU) begin
         sh = 16 * (1 - int'(a[1]));
         v  = (w >> sh) & 32'hFFFF;
         if (o == OP_LH && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else if (o == OP_LW) begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] w, input logic [31:0] d);
      int sh;
      logic [31:0] m;
      if (o == OP_SB) begin
         sh = 8 * (3 - int'(a[1:0]));
         m  = 32'hFF << sh;
         return (w & ~m) | ((d & 32'hFF) << sh);
      end
      if (o == OP_SH) begin
         sh = 16 * (1 - int'(a[1]));
         m  = 32'hFFFF << sh;
         return (w & ~m) | ((d & 32'hFFFF) << sh);
      end
      return d;
   endfunction

   // Expectations of the transaction in flight.
   bit          chk_en = 1'b0;
   bit          active = 1'b0;
   int          t_acc = 0;
   int          t_lat = 0;
   int          t_kind = 0;
   bit          t_mis = 1'b0;
   logic [31:0] t_rdata = 32'h0;
   logic [31:0] t_wword = 32'h0;
   logic [31:0] t_waddr = 32'h0;
   logic [31:0] hold_rdata = 32'h0;
   logic [31:0] obs_rdata = 32'h0;

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      int   k;
      logic e_stall, e_done, e_ce, e_we;
      if (chk_en) begin
         k       = cyc - t_acc;
         e_done  = active && (k == t_lat);
         e_stall = active && (k < t_lat);
         e_ce    = 1'b0;
         e_we    = 1'b0;
         if (active) begin
            case (t_kind)
               K_LOAD: e_ce = (k == 1);
               K_RMW: begin
                  e_we = (k >= 3) && (k < t_lat);
                  e_ce = (k == 1) || e_we;
               end
               K_SW: begin
                  e_ce = (k >= 1) && (k < t_lat);
                  e_we = e_ce;
               end
               default: ;
            endcase
         end
         chk("stall_req", {31'h0, stall_req}, {31'h0, e_stall});
         chk("done", {31'h0, done}, {31'h0, e_done});
         chk("ram_ce", {31'h0, ram_ce}, {31'h0, e_ce});
         chk("ram_we", {31'h0, ram_we}, {31'h0, e_we});
         if (e_ce) chk("ram_addr", ram_addr, t_waddr);
         if (e_we) chk("ram_wdata", ram_wdata, t_wword);
         if (e_done) begin
            chk("misalign", {31'h0, misalign}, {31'h0, t_mis});
            chk("rdata", rdata, t_rdata);
            hold_rdata = t_rdata;
            obs_rdata  = rdata;
         end else begin
            chk("rdata_hold", rdata, hold_rdata);
            chk("misalign_idle", {31'h0, misalign}, 32'h0);
         end
         if (!rst) hold_rdata = 32'h0;
      end
   end

   // ---------------- driver ----------------
   task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                      input int xl, input bit hold, input bit abort_it,
                      output logic [31:0] obs);
      logic [31:0] w;
      bit          m;
      w       = ref_mem[a[9:2]];
      m       = model_mis(o, a);
      t_waddr = {a[31:2], 2'b00};
      t_wword = model_store(o, a, w, wd);
      t_mis   = m;
      if (m) begin
         t_kind = K_MIS;  t_lat = 1;      t_rdata = 32'h0;
      end else if (o == OP_SW) begin
         t_kind = K_SW;   t_lat = 3 + xl; t_rdata = 32'h0;
      end else if (o == OP_SB || o == OP_SH) begin
         t_kind = K_RMW;  t_lat = 5 + xl; t_rdata = 32'h0;
      end else begin
         t_kind = K_LOAD; t_lat = 3;      t_rdata = model_load(o, a, w);
      end
      extra_lat = xl;
      op = o; addr = a; wdata = wd; req = 1'b1;
      t_acc  = cyc;
      active = 1'b1;
      @(posedge clk); #1;
      // Post-accept garbage on the request bus must not matter.
      req = hold; op = 3'($urandom); addr = $urandom; wdata = $urandom;
      if (abort_it) begin
         @(posedge clk); #1;
         rst = 1'b0; req = 1'b1;
         @(posedge clk); #1;
         active = 1'b0;
         @(posedge clk); #1;
         rst = 1'b1;
         obs = 32'h0;
         return;
      end
      repeat (t_lat) begin
         @(posedge clk); #1;
      end
      req    = 1'b0;
      active = 1'b0;
      if (!m && (o == OP_SB || o == OP_SH || o == OP_SW)) ref_mem[a[9:2]] = t_wword;
      obs = obs_rdata;
   endtask

   logic [31:0] r;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mem_init = 1'b0;
      chk_en   = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;

      // Directed cases on word 0x100 = 0x8899AABB.
      run(OP_LB,  32'h101, 32'h0, 0, 0, 0, r);  chk("lb_0x101", r, 32'hFFFFFF99);
      run(OP_LHU, 32'h102, 32'h0, 0, 0, 0, r);  chk("lhu_0x102", r, 32'h0000AABB);
      run(OP_LH,  32'h100, 32'h0, 0, 1, 0, r);  chk("lh_0x100", r, 32'hFFFF8899);
      run(OP_LBU, 32'h100, 32'h0, 0, 0, 0, r);  chk("lbu_0x100", r, 32'h00000088);
      run(OP_SB,  32'h103, 32'h12345677, 0, 0, 0, r);
      chk("sb_merge_word", t_wword, 32'h8899AA77);
      run(OP_LW,  32'h100, 32'h0, 0, 0, 0, r);  chk("lw_after_sb", r, 32'h8899AA77);
      run(OP_SW,  32'h104, 32'hDEADBEEF, 2, 0, 0, r);
      run(OP_LW,  32'h104, 32'h0, 0, 0, 0, r);  chk("lw_after_sw", r, 32'hDEADBEEF);
      run(OP_LW,  32'h102, 32'h0, 0, 0, 0, r);  chk("lw_misaligned", r, 32'h0);
      run(OP_SH,  32'h101, 32'hFFFF, 0, 1, 0, r);
      run(OP_LW,  32'h100, 32'h0, 0, 0, 0, r);  chk("word_after_mis", r, 32'h8899AA77);
      run(OP_SH,  32'h102, 32'h00001234, 1, 0, 0, r);
      run(OP_LW,  32'h100, 32'h0, 0, 0, 0, r);  chk("lw_after_sh", r, 32'h88991234);

      // SB aborted by reset before its write; next request must start fresh.
      run(OP_SB,  32'h100, 32'h00000011, 0, 0, 1, r);
      run(OP_LW,  32'h100, 32'h0, 0, 0, 0, r);  chk("lw_after_abort", r, 32'h88991234);

      // Randomized traffic on a small address window.
      for (int n = 0; n < 400; n++) begin
         logic [2:0]  ro;
         logic [31:0] ra;
         int          gap;
         ro  = 3'($urandom_range(0, 7));
         ra  = 32'h100 + $urandom_range(0, 63);
         run(ro, ra, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, r);
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk); #1;
         end
      end

      // Memory contents must agree with the reference.
      repeat (2) @(posedge clk);
      #1;
      for (int i = 32'h40; i < 32'h50; i++) chk("ram_contents", ram_mem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_access_ctrl
`default_nettype wire
